wb_mailbox: RTL

Wishbone B4 classic responder that attaches to the SoC's outbound Wishbone master port (the block-select 3 window) and gives firmware a word-wide, bidirectional mailbox to external logic. CPU writes go through an outbound FIFO to a valid/ready stream. An inbound stream fills an inbound FIFO that the CPU pops by reading. Status and control registers expose FIFO levels and sticky error flags.

---
 rtl/wb_mailbox.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_mailbox.sv
// wb_mailbox: Wishbone B4 classic mailbox with TX/RX word FIFOs; optional irq_o under WB_MAILBOX_IRQ_EN
module wb_mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk_i)
    if (push && !flush) mem[wp] <= din;
  assign head = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

module wb_mailbox #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0030_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [31:0]           wb_wdata_i,
  output logic [31:0]           wb_rdata_o,
  input  logic                  wb_wr_en_i,
  input  logic [3:0]            wb_byte_en_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [31:0]           m_data_o,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [31:0]           s_data_i
`ifdef WB_MAILBOX_IRQ_EN
  ,
  output logic                  irq_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic {IDLE, ACK} state_e;
  state_e state_q, state_d;
  logic acc, hit, wr, rd, tx_req, rx_req, stat_wr, ctrl_wr;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_en_q, irq_en_q, tx_ovf_q, rx_udf_q;
  logic [1:0] sel;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [31:0] tx_head, rx_head, status, ctrl_rd, rd_val;
  logic unused;
  assign unused = ^{wb_byte_en_i, wb_addr_i[1:0]};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    acc = state_q == IDLE && wb_cyc_i && wb_stb_i;
    state_d = acc ? ACK : IDLE;
  end
  assign wb_ack_o = state_q == ACK;
  assign hit = wb_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  assign sel = wb_addr_i[3:2];
  assign wr = acc & hit & wb_wr_en_i;
  assign rd = acc & hit & ~wb_wr_en_i;
  assign tx_req = wr & (sel == 2'd0);
  assign rx_req = rd & (sel == 2'd1);
  assign stat_wr = wr & (sel == 2'd2);
  assign ctrl_wr = wr & (sel == 2'd3);
  wb_mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush(ctrl_wr & wb_wdata_i[1]),
    .push(tx_req & ~tx_full), .pop(m_valid_o & m_ready_i), .din(wb_wdata_i),
    .head(tx_head), .count(tx_cnt), .full(tx_full), .empty(tx_empty)
  );
  wb_mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush(ctrl_wr & wb_wdata_i[2]),
    .push(s_valid_i & s_ready_o), .pop(rx_req & ~rx_empty), .din(s_data_i),
    .head(rx_head), .count(rx_cnt), .full(rx_full), .empty(rx_empty)
  );
  assign m_valid_o = tx_en_q & ~tx_empty;
  assign m_data_o = tx_empty ? '0 : tx_head;
  assign s_ready_o = ~rx_full;
  assign status = {6'd0, rx_udf_q, tx_ovf_q, 8'(rx_cnt), 8'(tx_cnt), 4'd0, rx_empty, rx_full, tx_empty, tx_full};
  assign ctrl_rd = {28'd0, irq_en_q, 2'b00, tx_en_q};
  assign rd_val = !rd ? '0 : sel == 2'd1 ? (rx_empty ? '0 : rx_head) : sel == 2'd2 ? status : sel == 2'd3 ? ctrl_rd : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wb_rdata_o <= '0;
      tx_en_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      wb_rdata_o <= rd_val;
      if (ctrl_wr) tx_en_q <= wb_wdata_i[0];
      tx_ovf_q <= (tx_ovf_q & ~(stat_wr & wb_wdata_i[24])) | (tx_req & tx_full);
      rx_udf_q <= (rx_udf_q & ~(stat_wr & wb_wdata_i[25])) | (rx_req & rx_empty);
    end
`ifdef WB_MAILBOX_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      irq_en_q <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= wb_wdata_i[3];
      irq_o <= (irq_en_q & ~rx_empty) | tx_ovf_q | rx_udf_q;
    end
`else
  assign irq_en_q = 1'b0;
`endif
endmodule
